// File: rtl/i2c_clk_gen_if.sv
// Bus between the I2C clock generator (master modport) and the byte-level
// master FSM / SCL pad logic (slave modport).
interface i2c_clk_gen_if;
  logic       ena;
  logic       scl_in;
  logic       scl_clk;
  logic       data_clk;
  logic       data_rise;
  logic       data_fall;
  logic [1:0] phase;
  logic       busy;
  logic       stretching;
  logic       timeout;

  modport master (
    input  ena, scl_in,
    output scl_clk, data_clk, data_rise, data_fall, phase, busy, stretching, timeout
  );

  modport slave (
    output ena, scl_in,
    input  scl_clk, data_clk, data_rise, data_fall, phase, busy, stretching, timeout
  );
endinterface

// File: rtl/i2c_clk_gen.sv
// I2C master clock generator: four-quarter bit period with slave clock-stretch hold.
// Optional stretch timeout enabled by defining I2C_STRETCH_TIMEOUT_EN.
module i2c_clk_gen #(
  parameter int DIVIDER        = 250,
  parameter int CBITS          = 10,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TBITS          = 13
) (
  input  logic          clk,
  input  logic          rst,
  i2c_clk_gen_if.master bus
);

  localparam int PERIOD = 4 * DIVIDER;

  if (DIVIDER < 2 || (2 ** CBITS) < PERIOD || TIMEOUT_CYCLES < 1 ||
      (2 ** TBITS) <= TIMEOUT_CYCLES) begin : g_param_check
    $error("i2c_clk_gen: illegal parameter combination");
  end

  // START is the one idle cycle between accepting ena and the first cnt=0 cycle
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic             scl_clk_q, scl_clk_d;
  logic             data_clk_q, data_clk_d;
  logic             data_rise_q, data_rise_d;
  logic             data_fall_q, data_fall_d;
  logic [1:0]       phase_q, phase_d;
  logic             busy_q, busy_d;
  logic             stretching_q, stretching_d;
  logic             stall;
  logic             in_q2;
  logic [1:0]       q_next;

  function automatic logic [1:0] quarter(input logic [CBITS-1:0] c);
    if (32'(c) < DIVIDER)          return 2'd0;
    else if (32'(c) < 2 * DIVIDER) return 2'd1;
    else if (32'(c) < 3 * DIVIDER) return 2'd2;
    else                           return 2'd3;
  endfunction

`ifdef I2C_STRETCH_TIMEOUT_EN
  logic [TBITS-1:0] tcnt_q, tcnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    in_q2   = (state_q == S_RUN) && (quarter(cnt_q) == 2'd2);
`ifdef I2C_STRETCH_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.ena) begin
          state_d = S_START;
`ifdef I2C_STRETCH_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (in_q2 && !bus.scl_in) begin
`ifdef I2C_STRETCH_TIMEOUT_EN
          // Counter saturates at the limit so the rest of this q2 runs unstretched
          if (32'(tcnt_q) < TIMEOUT_CYCLES) begin
            stall  = 1'b1;
            tcnt_d = tcnt_q + TBITS'(1);
          end else begin
            timeout_d = 1'b1;
          end
`else
          stall = 1'b1;
`endif
        end
        if (!stall) begin
          if (32'(cnt_q) == PERIOD - 1) begin
            cnt_d = '0;
            if (!bus.ena) state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CBITS'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef I2C_STRETCH_TIMEOUT_EN
    if (!in_q2) tcnt_d = '0;
`endif

    // Outputs are decoded from the post-edge state so they line up with cnt_q
    busy_d       = (state_d == S_RUN);
    q_next       = quarter(cnt_d);
    phase_d      = busy_d ? q_next : 2'd0;
    scl_clk_d    = busy_d ? q_next[1] : 1'b1;
    data_clk_d   = busy_d && (q_next == 2'd1 || q_next == 2'd2);
    data_rise_d  = busy_d && !stall && (32'(cnt_d) == DIVIDER);
    data_fall_d  = busy_d && !stall && (32'(cnt_d) == 3 * DIVIDER);
    stretching_d = stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      scl_clk_q    <= 1'b1;
      data_clk_q   <= 1'b0;
      data_rise_q  <= 1'b0;
      data_fall_q  <= 1'b0;
      phase_q      <= 2'd0;
      busy_q       <= 1'b0;
      stretching_q <= 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
      tcnt_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scl_clk_q    <= scl_clk_d;
      data_clk_q   <= data_clk_d;
      data_rise_q  <= data_rise_d;
      data_fall_q  <= data_fall_d;
      phase_q      <= phase_d;
      busy_q       <= busy_d;
      stretching_q <= stretching_d;
`ifdef I2C_STRETCH_TIMEOUT_EN
      tcnt_q       <= tcnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign bus.scl_clk    = scl_clk_q;
  assign bus.data_clk   = data_clk_q;
  assign bus.data_rise  = data_rise_q;
  assign bus.data_fall  = data_fall_q;
  assign bus.phase      = phase_q;
  assign bus.busy       = busy_q;
  assign bus.stretching = stretching_q;
`ifdef I2C_STRETCH_TIMEOUT_EN
  assign bus.timeout    = timeout_q;
`else
  assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_clk_gen.sv
// Self-checking bench for i2c_clk_gen: expected per-cycle trace is built from
// the quarter/stretch rules of each bit period, then compared cycle by cycle.
module tb_i2c_clk_gen;
  localparam int D = 4;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  i2c_clk_gen_if bus_if ();

  i2c_clk_gen #(
    .DIVIDER(D), .CBITS(5), .TIMEOUT_CYCLES(T), .TBITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       busy;
    bit [1:0] phase;
    bit       scl, data, rise, fall, st, tmo;
    bit       ena, scl_in;  // inputs to drive after this cycle is checked
  } exp_t;

  exp_t q[$];
  bit   tmo_m;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_entry(exp_t e);
    chk("busy",       32'(bus_if.busy),       32'(e.busy));
    chk("phase",      32'(bus_if.phase),      32'(e.phase));
    chk("scl_clk",    32'(bus_if.scl_clk),    32'(e.scl));
    chk("data_clk",   32'(bus_if.data_clk),   32'(e.data));
    chk("data_rise",  32'(bus_if.data_rise),  32'(e.rise));
    chk("data_fall",  32'(bus_if.data_fall),  32'(e.fall));
    chk("stretching", 32'(bus_if.stretching), 32'(e.st));
    chk("timeout",    32'(bus_if.timeout),    32'(e.tmo));
  endtask

  // Quarter table: SCL low in q0/q1, data strobe high in q1/q2
  function automatic exp_t mk(bit busy, bit [1:0] ph, bit st, bit rise, bit fall,
                              bit pull, bit en);
    exp_t e;
    e.busy   = busy;
    e.phase  = ph;
    e.scl    = busy ? ph[1] : 1'b1;
    e.data   = busy ? (ph[0] ^ ph[1]) : 1'b0;
    e.rise   = rise;
    e.fall   = fall;
    e.st     = st;
    e.tmo    = tmo_m;
    e.ena    = en;
    e.scl_in = e.scl & ~pull;
    return e;
  endfunction

  task automatic push_idle(int n, bit en);
    repeat (n) q.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, en));
  endtask

  task automatic start_run();
    q.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    tmo_m = 1'b0;
    q.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  // One bit period; the slave holds SCL low for the first h cycles of q2.
  task automatic push_period(int h, int drop_at);
    int p = 0;
    int holds = h;
`ifdef I2C_STRETCH_TIMEOUT_EN
    if (h > T) holds = T;
`endif
    for (int qq = 0; qq < 4; qq++) begin
      int len = (qq == 2) ? D + holds : D;
      for (int j = 0; j < len; j++) begin
        bit st = 1'b0;
        bit pull = 1'b0;
        if (qq == 2) begin
          st   = (j >= 1) && (j <= holds);
          pull = (j < h);
`ifdef I2C_STRETCH_TIMEOUT_EN
          if (h > T && j == T + 1) tmo_m = 1'b1;
`endif
        end
        q.push_back(mk(1'b1, 2'(qq), st, (qq == 1 && j == 0), (qq == 3 && j == 0),
                       pull, !(drop_at >= 0 && p >= drop_at)));
        p++;
      end
    end
  endtask

  task automatic run_queue();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      @(posedge clk);
      #1;
      cyc++;
      check_entry(e);
      bus_if.ena    = e.ena;
      bus_if.scl_in = e.scl_in;
    end
  endtask

  initial begin
    int base;
    bus_if.ena    = 1'b0;
    bus_if.scl_in = 1'b1;
    tmo_m         = 1'b0;
    rst           = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
      check_entry(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    rst = 1'b0;

    // Run A: plain, stretched, random and over-limit stretches, then ena drop at cnt=6
    push_idle(5, 1'b0);
    start_run();
    push_period(0, -1);
    push_period(0, -1);
    push_period(10, -1);
    push_period(int'($urandom_range(1, 7)), -1);
    push_period(12, -1);
    push_period(0, 6);
    push_idle(4, 1'b0);
    run_queue();

    // Run B: restart, then reset in the middle of a stretch
    start_run();
    push_period(12, -1);
    push_period(int'($urandom_range(0, 3)), -1);
    base = q.size();
    push_period(5, -1);
    while (q.size() > base + 2 * D + 3) void'(q.pop_back());
    run_queue();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    tmo_m = 1'b0;
    check_entry(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst           = 1'b0;
    bus_if.ena    = 1'b0;
    bus_if.scl_in = 1'b1;
    push_idle(3, 1'b0);
    run_queue();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
